pipe_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the five-stage RV32I pipeline. Generates per-stage `stall`/`flush` for the F/D, D/E, E/M and M/W pipeline registers, covering three cases:
- load-use hazards;
- taken branches and jumps;
- multi-cycle data-memory accesses, via a wait-state FSM with timeout.

It also produces E-stage forwarding selects and two saturating performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: load-use stalls,
// branch flushes, data-memory wait-state FSM with timeout, forwarding selects and perf counters.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic [4:0]       rd_E,
  input  logic             reg_wr_E,
  input  logic [1:0]       sel_wb_E,
  input  logic             pc_src_E,
  input  logic [4:0]       rd_M,
  input  logic             reg_wr_M,
  input  logic             mem_req_M,
  input  logic             dmem_ready,
  input  logic [4:0]       rd_W,
  input  logic             reg_wr_W,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_W,
  output logic [1:0]       fwd_a_E,
  output logic [1:0]       fwd_b_E,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       mem_state_dbg
);

  localparam int WC_W = $clog2(TIMEOUT);
  localparam logic [1:0] M_IDLE = 2'd0;
  localparam logic [1:0] M_WAIT = 2'd1;
  localparam logic [1:0] M_ERR  = 2'd2;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             mem_stall, lu, act_lu, act_br;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    case (state_q)
      M_IDLE: begin
        if (mem_req_M && !dmem_ready) begin
          state_d    = M_WAIT;
          wait_cnt_d = '0;
        end
      end
      M_WAIT: begin
        if (dmem_ready) begin
          state_d = M_IDLE;
        end else if (wait_cnt_q == WC_LAST) begin
          state_d = M_ERR;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      M_ERR:   state_d = M_ERR;
      default: state_d = M_IDLE;
    endcase
  end

  assign mem_stall = ((state_q == M_IDLE) && mem_req_M && !dmem_ready) ||
                     ((state_q == M_WAIT) && !dmem_ready) ||
                     (state_q == M_ERR);

  assign lu = reg_wr_E && (sel_wb_E == 2'b01) && (rd_E != 5'd0) &&
              ((rd_E == rs1_D) || (rd_E == rs2_D));

  // A taken branch makes the D instruction wrong-path, so it wins over load-use;
  // a memory stall freezes E, so both wait for the first non-stalled cycle.
  assign act_br = pc_src_E && !mem_stall;
  assign act_lu = lu && !pc_src_E && !mem_stall;

  assign stall_F = rst && (mem_stall || act_lu);
  assign stall_D = rst && (mem_stall || act_lu);
  assign stall_E = rst && mem_stall;
  assign stall_M = rst && mem_stall;
  assign flush_D = rst && act_br;
  assign flush_E = rst && (act_br || act_lu);
  assign flush_W = rst && mem_stall;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (reg_wr_M && (rd_M != 5'd0) && (rd_M == rs))      return 2'b10;
    else if (reg_wr_W && (rd_W != 5'd0) && (rd_W == rs)) return 2'b01;
    else                                                 return 2'b00;
  endfunction

  assign fwd_a_E = rst ? fwd_sel(rs1_E) : 2'b00;
  assign fwd_b_E = rst ? fwd_sel(rs2_E) : 2'b00;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_F && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_D && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= M_IDLE;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_err       = err_q;
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;
  assign mem_state_dbg = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: table of single-cycle vectors plus hand-written
// sequences for memory wait, timeout, async reset and counter saturation.
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic reg_wr_E, pc_src_E, reg_wr_M, mem_req_M, dmem_ready, reg_wr_W;
  logic [1:0] sel_wb_E;
  logic stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W, mem_err;
  logic [1:0] fwd_a_E, fwd_b_E, mem_state_dbg;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [10:0] exp_q[$];

  typedef struct {
    string      name;
    logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E;
    logic       reg_wr_E;
    logic [1:0] sel_wb_E;
    logic       pc_src_E;
    logic [4:0] rd_M;
    logic       reg_wr_M;
    logic [4:0] rd_W;
    logic       reg_wr_W;
    logic       mem_req_M, dmem_ready;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[12];

  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst_n),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
    .rd_E(rd_E), .reg_wr_E(reg_wr_E), .sel_wb_E(sel_wb_E), .pc_src_E(pc_src_E),
    .rd_M(rd_M), .reg_wr_M(reg_wr_M), .mem_req_M(mem_req_M), .dmem_ready(dmem_ready),
    .rd_W(rd_W), .reg_wr_W(reg_wr_W),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W),
    .fwd_a_E(fwd_a_E), .fwd_b_E(fwd_b_E), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_state_dbg(mem_state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  // Packed expected outputs: {sF,sD,sE,sM,fD,fE,fW,fwd_a[1:0],fwd_b[1:0]}
  function automatic logic [10:0] ex(input logic sf, sd, se, sm, fd, fe, fw,
                                     input logic [1:0] fa, fb);
    return {sf, sd, se, sm, fd, fe, fw, fa, fb};
  endfunction

  function automatic vec_t mkv(input string name,
                               input logic [4:0] r1d, r2d, r1e, r2e, rde,
                               input logic we, input logic [1:0] sel, input logic pc,
                               input logic [4:0] rdm, input logic wm,
                               input logic [4:0] rdw, input logic ww,
                               input logic req, rdy, input logic [10:0] e);
    vec_t v;
    v.name = name; v.rs1_D = r1d; v.rs2_D = r2d; v.rs1_E = r1e; v.rs2_E = r2e;
    v.rd_E = rde; v.reg_wr_E = we; v.sel_wb_E = sel; v.pc_src_E = pc;
    v.rd_M = rdm; v.reg_wr_M = wm; v.rd_W = rdw; v.reg_wr_W = ww;
    v.mem_req_M = req; v.dmem_ready = rdy; v.exp = e;
    return v;
  endfunction

  function automatic vec_t idle_v(input string name);
    return mkv(name, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 11'd0);
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input vec_t v);
    rs1_D = v.rs1_D; rs2_D = v.rs2_D; rs1_E = v.rs1_E; rs2_E = v.rs2_E;
    rd_E = v.rd_E; reg_wr_E = v.reg_wr_E; sel_wb_E = v.sel_wb_E; pc_src_E = v.pc_src_E;
    rd_M = v.rd_M; reg_wr_M = v.reg_wr_M; rd_W = v.rd_W; reg_wr_W = v.reg_wr_W;
    mem_req_M = v.mem_req_M; dmem_ready = v.dmem_ready;
  endtask

  // ---------------- scoreboard ----------------
  task automatic compare_out(input string name);
    logic [10:0] got, want;
    got = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W, fwd_a_E, fwd_b_E};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %b", name, got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s: outputs got %b expected %b (sF sD sE sM fD fE fW fa fb)",
                 name, got, want);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at posedge+1; drives one cycle, samples at the falling edge.
  task automatic step(input vec_t v);
    drive(v);
    exp_q.push_back(v.exp);
    @(negedge clk);
    compare_out(v.name);
    @(posedge clk);
    #1;
  endtask

  // Reset with hazard inputs active to show outputs are gated while rst is low.
  task automatic do_reset(input string name);
    vec_t v;
    v = mkv(name, 5, 0, 7, 0, 5, 1, 2'b01, 1, 7, 1, 0, 0, 1, 0, 11'd0);
    rst_n = 1'b0;
    drive(v);
    #2;
    exp_q.push_back(11'd0);
    compare_out({name, "_outs"});
    chk({name, "_stall_cnt"}, 32'(stall_cnt), 0);
    chk({name, "_flush_cnt"}, 32'(flush_cnt), 0);
    chk({name, "_state"}, 32'(mem_state_dbg), 0);
    chk({name, "_mem_err"}, 32'(mem_err), 0);
    drive(idle_v(name));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t v;
    rst_n = 1'b0;
    drive(idle_v("init"));

    //         name         r1D r2D r1E r2E rdE we sel   pc rdM wM rdW wW rq rdy expected
    tbl[0]  = mkv("lu_rs1",    5, 0, 0, 0, 5, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, ex(1,1,0,0,0,1,0,2'b00,2'b00));
    tbl[1]  = mkv("lu_rd0",    0, 0, 0, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,2'b00,2'b00));
    tbl[2]  = mkv("lu_rs2",    1, 9, 0, 0, 9, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, ex(1,1,0,0,0,1,0,2'b00,2'b00));
    tbl[3]  = mkv("alu_wb",    5, 0, 0, 0, 5, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,2'b00,2'b00));
    tbl[4]  = mkv("load_nowr", 5, 0, 0, 0, 5, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,2'b00,2'b00));
    tbl[5]  = mkv("br_lu",     5, 0, 0, 0, 5, 1, 2'b01, 1, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,1,1,0,2'b00,2'b00));
    tbl[6]  = mkv("br",        0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,1,1,0,2'b00,2'b00));
    tbl[7]  = mkv("fwd_m",     0, 0, 7, 0, 0, 0, 2'b00, 0, 7, 1, 7, 1, 0, 0, ex(0,0,0,0,0,0,0,2'b10,2'b00));
    tbl[8]  = mkv("fwd_w",     0, 0, 7, 0, 0, 0, 2'b00, 0, 7, 0, 7, 1, 0, 0, ex(0,0,0,0,0,0,0,2'b01,2'b00));
    tbl[9]  = mkv("fwd_rs0",   0, 0, 0, 0, 0, 0, 2'b00, 0, 7, 1, 7, 1, 0, 0, ex(0,0,0,0,0,0,0,2'b00,2'b00));
    tbl[10] = mkv("fwd_ab",    0, 0, 4, 3, 0, 0, 2'b00, 0, 4, 1, 3, 1, 0, 0, ex(0,0,0,0,0,0,0,2'b10,2'b01));
    tbl[11] = mkv("mem_fast",  0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, ex(0,0,0,0,0,0,0,2'b00,2'b00));

    do_reset("reset0");
    for (int i = 0; i < 12; i++) begin
      step(tbl[i]);
      chk({tbl[i].name, "_state"}, 32'(mem_state_dbg), 0);
    end

    // Load-use costs one stall; branch+load-use flushes without stalling.
    do_reset("reset_lu");
    step(tbl[0]);
    step(idle_v("lu_after"));
    chk("lu_stall_cnt", 32'(stall_cnt), 1);
    step(tbl[5]);
    chk("brlu_flush_cnt", 32'(flush_cnt), 1);
    chk("brlu_stall_cnt", 32'(stall_cnt), 1);

    // Memory wait of 3 cycles with a branch held in E.
    do_reset("reset_mw");
    v = idle_v("mw_stall");
    v.mem_req_M = 1'b1;
    v.pc_src_E  = 1'b1;
    v.exp       = ex(1,1,1,1,0,0,1,2'b00,2'b00);
    for (int i = 0; i < 3; i++) begin
      step(v);
      chk("mw_state_wait", 32'(mem_state_dbg), 1);
      chk("mw_flush_cnt_held", 32'(flush_cnt), 0);
    end
    v.name       = "mw_release";
    v.dmem_ready = 1'b1;
    v.exp        = ex(0,0,0,0,1,1,0,2'b00,2'b00);
    step(v);
    chk("mw_state_idle", 32'(mem_state_dbg), 0);
    chk("mw_stall_cnt", 32'(stall_cnt), 3);
    chk("mw_flush_cnt", 32'(flush_cnt), 1);
    step(idle_v("mw_after"));

    // Timeout: 1 IDLE + TIMEOUT WAIT stall cycles, then sticky error.
    do_reset("reset_to");
    v = idle_v("to_stall");
    v.mem_req_M = 1'b1;
    v.exp       = ex(1,1,1,1,0,0,1,2'b00,2'b00);
    for (int i = 0; i < 5; i++) begin
      step(v);
      chk("to_mem_err", 32'(mem_err), (i == 4) ? 1 : 0);
    end
    chk("to_state_err", 32'(mem_state_dbg), 2);
    v.name      = "to_err_hold";
    v.mem_req_M = 1'b0;
    step(v);
    chk("to_err_stall_cnt", 32'(stall_cnt), 6);
    chk("to_err_sticky", 32'(mem_err), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("to_async_mem_err", 32'(mem_err), 0);
    chk("to_async_state", 32'(mem_state_dbg), 0);
    chk("to_async_stall_F", 32'(stall_F), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(idle_v("to_released"));

    // Saturation of a 4-bit stall counter over a 20-cycle stall.
    do_reset("reset_sat");
    v = idle_v("sat_stall");
    v.mem_req_M = 1'b1;
    v.exp       = ex(1,1,1,1,0,0,1,2'b00,2'b00);
    for (int i = 0; i < 20; i++) begin
      step(v);
    end
    chk("sat_stall_cnt", 32'(stall_cnt), 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
